// File: rtl/float32_to_int_seq_pkg.sv
// Shared float32 field layout, int32 limits and converter state encodings.
// Also used by the unpack stage so the recip/divide units can share it.
package float32_to_int_seq_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;

    localparam logic [7:0]  F32_BIAS        = 8'd127;
    localparam logic [7:0]  F32_EXP_SPECIAL = 8'hFF;
    // Biased exponents where the significand is already aligned (e = 23) and where int32 saturates (e = 31).
    localparam logic [7:0]  F32_EXP_ALIGN   = 8'd150;
    localparam logic [7:0]  F32_EXP_SAT     = 8'd158;
    localparam logic [31:0] F32_INT32_MIN   = 32'hCF00_0000;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/float32_to_int_seq_f32_unpack.sv
// Combinational float32 field split and classification, plus the
// alignment shift count and direction needed to reach an integer.
import float32_to_int_seq_pkg::*;

module f32_unpack (
    input  logic [31:0] val,
    output logic        sign,
    output logic [31:0] mant,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_small,
    output logic        is_sat,
    output logic [5:0]  shamt,
    output logic        dir
);
    logic [7:0]  exp_f;
    logic [22:0] frac_f;
    logic [7:0]  diff;

    always_comb begin
        sign     = val[SIGN_BIT];
        exp_f    = val[EXP_MSB:EXP_LSB];
        frac_f   = val[FRAC_MSB:0];
        mant     = {8'd0, 1'b1, frac_f};
        is_nan   = (exp_f == F32_EXP_SPECIAL) && (frac_f != 23'd0);
        is_inf   = (exp_f == F32_EXP_SPECIAL) && (frac_f == 23'd0);
        is_small = (exp_f < F32_BIAS);
        is_sat   = (exp_f >= F32_EXP_SAT) && (exp_f != F32_EXP_SPECIAL);
        // dir = 1 means shift left; only meaningful for 0 <= e <= 30
        dir      = (exp_f >= F32_EXP_ALIGN);
        diff     = dir ? (exp_f - F32_EXP_ALIGN) : (F32_EXP_ALIGN - exp_f);
        shamt    = diff[5:0];
    end

endmodule

// File: rtl/float32_to_int_seq.sv
// Sequential float32 -> int32 converter, truncating toward zero; the
// significand is aligned one bit per clock in the SHIFT state.
import float32_to_int_seq_pkg::*;

module float32_to_int_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] val,
    output logic        busy,
    output logic        rdy,
    output logic [31:0] result,
    output logic        ovf
);
    state_t      state, state_nx;
    logic [31:0] mag;
    logic [5:0]  cnt;
    logic        dir_q;
    logic        sign_q;

    logic        u_sign, u_nan, u_inf, u_small, u_sat, u_dir;
    logic [31:0] u_mant;
    logic [5:0]  u_shamt;
    logic        accept, normal;

    f32_unpack u_unpack (
        .val      (val),
        .sign     (u_sign),
        .mant     (u_mant),
        .is_nan   (u_nan),
        .is_inf   (u_inf),
        .is_small (u_small),
        .is_sat   (u_sat),
        .shamt    (u_shamt),
        .dir      (u_dir)
    );

    assign accept = (state == ST_IDLE) && start;
    assign normal = !(u_nan || u_inf || u_small || u_sat);
    assign busy   = (state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start && normal) state_nx = ST_SHIFT;
            ST_SHIFT: if (cnt == 6'd0)     state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag    <= 32'd0;
            cnt    <= 6'd0;
            dir_q  <= 1'b0;
            sign_q <= 1'b0;
            result <= 32'd0;
            ovf    <= 1'b0;
            rdy    <= 1'b0;
        end else if (accept) begin
            rdy <= 1'b0;
            if (u_nan) begin
                result <= 32'd0;
                ovf    <= 1'b1;
                rdy    <= 1'b1;
            end else if (u_inf) begin
                result <= u_sign ? INT32_MIN : INT32_MAX;
                ovf    <= 1'b1;
                rdy    <= 1'b1;
            end else if (u_small) begin
                result <= 32'd0;
                ovf    <= 1'b0;
                rdy    <= 1'b1;
            end else if (u_sat) begin
                // -2^31 is the one e >= 31 value that is representable
                if (val == F32_INT32_MIN) begin
                    result <= INT32_MIN;
                    ovf    <= 1'b0;
                end else begin
                    result <= u_sign ? INT32_MIN : INT32_MAX;
                    ovf    <= 1'b1;
                end
                rdy <= 1'b1;
            end else begin
                mag    <= u_mant;
                cnt    <= u_shamt;
                dir_q  <= u_dir;
                sign_q <= u_sign;
            end
        end else if (state == ST_SHIFT) begin
            if (cnt != 6'd0) begin
                mag <= dir_q ? {mag[30:0], 1'b0} : {1'b0, mag[31:1]};
                cnt <= cnt - 6'd1;
            end else begin
                result <= sign_q ? (32'd0 - mag) : mag;
                ovf    <= 1'b0;
                rdy    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_float32_to_int_seq.sv
// Directed-vector bench for float32_to_int_seq: values, ovf, latency, busy,
// reset abort and start held across a conversion.
module tb_float32_to_int_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] val;
    logic        busy, rdy, ovf;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    float32_to_int_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .val    (val),
        .busy   (busy),
        .rdy    (rdy),
        .result (result),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Drive one start pulse and wait (bounded) for rdy; returns observations only.
    task automatic convert(input logic [31:0] v, output logic [31:0] res,
                           output logic o, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        val   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        val   = 32'hDEAD_BEEF;
        lat   = 1;
        bcnt  = 0;
        while (!rdy && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        o   = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; val = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rdy !== 1'b0)     begin errors++; $display("FAIL reset_rdy got %b want 0", rdy); end
        checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    endtask

    task automatic test_normal();
        logic [31:0] vin [4] = '{32'h4341_0000, 32'h4EFF_FFFF, 32'hBF80_0000, 32'h3FAA_AAAB};
        logic [31:0] rexp[4] = '{32'h0000_00C1, 32'h7FFF_FF80, 32'hFFFF_FFFF, 32'h0000_0001};
        int          lexp[4] = '{18, 9, 25, 25};
        logic [31:0] r;
        logic        o;
        int          lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            convert(vin[i], r, o, lat, bcnt);
            checks++; if (r !== rexp[i]) begin errors++; $display("FAIL normal_result[%h] got %h want %h", vin[i], r, rexp[i]); end
            checks++; if (o !== 1'b0)    begin errors++; $display("FAIL normal_ovf[%h] got %b want 0", vin[i], o); end
            checks++; if (lat != lexp[i]) begin errors++; $display("FAIL normal_latency[%h] got %0d want %0d", vin[i], lat, lexp[i]); end
            checks++; if (bcnt != lexp[i] - 1) begin errors++; $display("FAIL normal_busy[%h] got %0d want %0d", vin[i], bcnt, lexp[i] - 1); end
            if (i == 0) begin
                repeat (3) @(posedge clk);
                #1;
                checks++; if (rdy !== 1'b1 || result !== 32'h0000_00C1)
                    begin errors++; $display("FAIL rdy_hold got rdy=%b result=%h want 1/000000c1", rdy, result); end
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] vin [6] = '{32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000,
                                 32'hBF00_0000, 32'h8000_0000, 32'hFF80_0000};
        logic [31:0] rexp[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000,
                                 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
        logic        oexp[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] r;
        logic        o;
        int          lat, bcnt;
        for (int i = 0; i < 6; i++) begin
            convert(vin[i], r, o, lat, bcnt);
            checks++; if (r !== rexp[i]) begin errors++; $display("FAIL special_result[%h] got %h want %h", vin[i], r, rexp[i]); end
            checks++; if (o !== oexp[i]) begin errors++; $display("FAIL special_ovf[%h] got %b want %b", vin[i], o, oexp[i]); end
            checks++; if (lat != 1)      begin errors++; $display("FAIL special_latency[%h] got %0d want 1", vin[i], lat); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        logic        o;
        int          lat, bcnt;
        // leave a nonzero result so the reset clear is visible
        convert(32'h4341_0000, r, o, lat, bcnt);
        @(negedge clk);
        start = 1'b1; val = 32'h4080_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || rdy !== 1'b0 || result !== 32'd0)
            begin errors++; $display("FAIL abort_clear got busy=%b rdy=%b result=%h want 0/0/0", busy, rdy, result); end
        convert(32'h4080_0000, r, o, lat, bcnt);
        checks++; if (r !== 32'd4 || o !== 1'b0)
            begin errors++; $display("FAIL abort_reconvert got %h ovf=%b want 00000004 ovf=0", r, o); end
        checks++; if (lat != 23) begin errors++; $display("FAIL abort_latency got %0d want 23", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; val = 32'h4080_0000;
        @(posedge clk);
        #1;
        // start stays high; a different operand during SHIFT must be ignored
        val = 32'h4341_0000;
        lat = 1;
        while (!rdy && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (result !== 32'd4 || lat != 23)
            begin errors++; $display("FAIL b2b_first got %h lat=%0d want 00000004 lat=23", result, lat); end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (rdy !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL b2b_accept got rdy=%b busy=%b want 0/1", rdy, busy); end
        lat = 1;
        while (!rdy && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (result !== 32'h0000_00C1 || lat != 18)
            begin errors++; $display("FAIL b2b_second got %h lat=%0d want 000000c1 lat=18", result, lat); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
